// File: rtl/cmd_source_arbiter_if.sv
// Byte-stream bundle between two byte sources, the arbiter and the control unit.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface cmd_source_arbiter_if;
    logic [7:0] src0_byte;
    logic       src0_ready;
    logic       src0_next;
    logic [7:0] src1_byte;
    logic       src1_ready;
    logic       src1_next;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       out_next;
    logic       hold_off;
    logic       grant;
    logic       locked;

    modport slave (
        input  src0_byte, src0_ready, src1_byte, src1_ready, out_next, hold_off,
        output src0_next, src1_next, out_byte, out_ready, grant, locked
    );

    modport master (
        output src0_byte, src0_ready, src1_byte, src1_ready, out_next, hold_off,
        input  src0_next, src1_next, out_byte, out_ready, grant, locked
    );
endinterface

// File: rtl/cmd_source_arbiter.sv
// Locks the command byte stream onto one of two sources for a whole packet and
// releases the lock after IdleTimeout cycles without a consumed byte.
module cmd_source_arbiter #(
    parameter int unsigned IdleTimeout = 1024
) (
    input logic                 clk,
    input logic                 reset,
    cmd_source_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(IdleTimeout + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(IdleTimeout - 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gnt_ready;
    logic            is_locked;

    assign gnt_ready = grant_q ? bus.src1_ready : bus.src0_ready;
    assign is_locked = (state_q == StLocked);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.hold_off && (bus.src0_ready || bus.src1_ready)) begin
                    state_d = StLocked;
                    cnt_d   = '0;
                    // Round-robin on a tie: the source not served last time wins.
                    if (bus.src0_ready && bus.src1_ready) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = bus.src1_ready;
                    end
                end
            end
            StLocked: begin
                if (bus.out_next) begin
                    cnt_d = '0;
                end else if (!gnt_ready) begin
                    if (cnt_q == CntMax) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Pure mux paths: no buffering between the sources and the control unit.
    assign bus.locked    = is_locked;
    assign bus.grant     = grant_q;
    assign bus.out_byte  = grant_q ? bus.src1_byte : bus.src0_byte;
    assign bus.out_ready = is_locked && gnt_ready;
    assign bus.src0_next = is_locked && !grant_q && bus.out_next;
    assign bus.src1_next = is_locked && grant_q && bus.out_next;
endmodule

// File: tb/tb_cmd_source_arbiter.sv
// Bench for cmd_source_arbiter: directed scenarios with literal expectations plus a
// random phase, all outputs compared every cycle against a packet-level model.
module tb_cmd_source_arbiter;
    localparam int unsigned T = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cmd_source_arbiter_if bus ();

    cmd_source_arbiter #(.IdleTimeout(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the stream, who was served last, and how many empty,
    // unconsumed cycles have passed since the lock began or the last consume.
    bit m_locked = 1'b0;
    bit m_grant  = 1'b0;
    bit m_last   = 1'b1;
    int m_empty  = 0;

    always @(negedge clk) begin
        bit g_rdy;
        if (reset) begin
            m_locked = 1'b0;
            m_grant  = 1'b0;
            m_last   = 1'b1;
            m_empty  = 0;
        end
        g_rdy = m_grant ? bus.src1_ready : bus.src0_ready;
        check("locked", bus.locked, m_locked);
        check("grant", bus.grant, m_grant);
        check("out_ready", bus.out_ready, m_locked && g_rdy);
        check("src0_next", bus.src0_next, m_locked && !m_grant && bus.out_next);
        check("src1_next", bus.src1_next, m_locked && m_grant && bus.out_next);
        if (m_locked && g_rdy) begin
            check("out_byte", bus.out_byte, m_grant ? bus.src1_byte : bus.src0_byte);
        end
        if (!reset) begin
            if (!m_locked) begin
                if (!bus.hold_off && (bus.src0_ready || bus.src1_ready)) begin
                    m_locked = 1'b1;
                    m_empty  = 0;
                    if (bus.src0_ready && bus.src1_ready) m_grant = !m_last;
                    else m_grant = bus.src1_ready;
                end
            end else if (bus.out_next) begin
                m_empty = 0;
            end else if (!g_rdy) begin
                // The T-th empty cycle in a row ends the packet.
                if (m_empty + 1 >= T) begin
                    m_locked = 1'b0;
                    m_last   = m_grant;
                end else begin
                    m_empty++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (bus.locked && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int  n;
        int  c0;
        int  c1;
        int  bad;
        bit  n0s;
        bit  n1s;
        bit  prev_rdy;

        bus.src0_byte  = 8'h00;
        bus.src0_ready = 1'b0;
        bus.src1_byte  = 8'h00;
        bus.src1_ready = 1'b0;
        bus.out_next   = 1'b0;
        bus.hold_off   = 1'b0;
        repeat (2) tick();

        check("rst_locked", bus.locked, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_out_ready", bus.out_ready, 0);
        check("rst_nexts", {bus.src0_next, bus.src1_next}, 0);

        // Single requester on source 1.
        reset          = 1'b0;
        bus.src1_ready = 1'b1;
        bus.src1_byte  = 8'h05;
        tick();
        check("acq_locked", bus.locked, 1);
        check("acq_grant", bus.grant, 1);
        check("acq_byte", bus.out_byte, 8'h05);
        check("acq_ready", bus.out_ready, 1);
        bus.out_next = 1'b1;
        #1;
        check("acq_consume", bus.src1_next, 1);
        tick();
        bus.out_next   = 1'b0;
        bus.src1_ready = 1'b0;
        wait_release(n);
        check("release_edges", n, T);

        // Round-robin on simultaneous requests.
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus.src0_byte  = 8'hA0;
        bus.src1_byte  = 8'hB1;
        bus.src0_ready = 1'b1;
        bus.src1_ready = 1'b1;
        tick();
        check("rr_first", bus.grant, 0);
        check("rr_first_byte", bus.out_byte, 8'hA0);
        bus.src0_ready = 1'b0;
        bus.src1_ready = 1'b0;
        wait_release(n);
        check("rr_release1", n, T);
        bus.src0_ready = 1'b1;
        bus.src1_ready = 1'b1;
        tick();
        check("rr_second", bus.grant, 1);
        check("rr_second_byte", bus.out_byte, 8'hB1);
        bus.src0_ready = 1'b0;
        bus.src1_ready = 1'b0;
        wait_release(n);
        bus.src0_byte  = 8'h10;
        bus.src0_ready = 1'b1;
        bus.src1_ready = 1'b1;
        tick();
        check("rr_third", bus.grant, 0);

        // Five-byte packet from source 0 while source 1 keeps requesting.
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 5; i++) begin
            bus.src0_byte  = 8'h10 + 8'(i);
            bus.src0_ready = 1'b1;
            tick();
            bus.out_next = 1'b1;
            #1;
            check("pkt_byte", bus.out_byte, 8'h10 + 8'(i));
            c0 += int'(bus.src0_next);
            c1 += int'(bus.src1_next);
            tick();
            bus.out_next = 1'b0;
        end
        check("pkt_src0_nexts", c0, 5);
        check("pkt_src1_nexts", c1, 0);
        bus.src0_ready = 1'b0;
        wait_release(n);
        check("pkt_release", n, T);
        bus.src1_ready = 1'b0;
        repeat (2) tick();
        wait_release(n);

        // Byte reappearing mid-timeout holds the lock; consume restarts the count.
        bus.src0_byte  = 8'h33;
        bus.src0_ready = 1'b1;
        tick();
        bus.out_next = 1'b1;
        tick();
        bus.out_next   = 1'b0;
        bus.src0_ready = 1'b0;
        tick();
        bus.src0_byte  = 8'h34;
        bus.src0_ready = 1'b1;
        repeat (8) tick();
        check("reappear_held", bus.locked, 1);
        bus.out_next = 1'b1;
        tick();
        bus.out_next   = 1'b0;
        bus.src0_ready = 1'b0;
        wait_release(n);
        check("reappear_release", n, T);

        // Spurious next while idle.
        bus.out_next = 1'b1;
        #1;
        check("spurious_nexts", {bus.src0_next, bus.src1_next}, 0);
        tick();
        bus.out_next = 1'b0;

        // hold_off blocks acquisition but never breaks a lock.
        bus.hold_off   = 1'b1;
        bus.src0_byte  = 8'h44;
        bus.src0_ready = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.locked || bus.out_ready) bad++;
        end
        check("hold_off_idle_cycles", bad, 0);
        bus.hold_off = 1'b0;
        tick();
        check("hold_off_acq", bus.locked, 1);
        check("hold_off_grant", bus.grant, 0);
        bus.hold_off = 1'b1;
        repeat (5) tick();
        check("hold_off_keeps_lock", bus.locked, 1);

        // Asynchronous reset mid-packet.
        bus.out_next = 1'b1;
        #1;
        check("pre_reset_next", bus.src0_next, 1);
        reset = 1'b1;
        #1;
        check("async_locked", bus.locked, 0);
        check("async_ready", bus.out_ready, 0);
        check("async_nexts", {bus.src0_next, bus.src1_next}, 0);
        tick();
        reset          = 1'b0;
        bus.out_next   = 1'b0;
        bus.hold_off   = 1'b0;
        bus.src0_ready = 1'b0;
        bus.src1_byte  = 8'h77;
        bus.src1_ready = 1'b1;
        tick();
        check("post_reset_grant", bus.grant, 1);
        check("post_reset_locked", bus.locked, 1);
        bus.src1_ready = 1'b0;
        wait_release(n);

        // Random traffic checked by the model every cycle.
        n0s      = 1'b0;
        n1s      = 1'b0;
        prev_rdy = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (n0s || !bus.src0_ready) begin
                bus.src0_ready = ($urandom_range(5) == 0);
                if (bus.src0_ready) bus.src0_byte = 8'($urandom);
            end
            if (n1s || !bus.src1_ready) begin
                bus.src1_ready = ($urandom_range(5) == 0);
                if (bus.src1_ready) bus.src1_byte = 8'($urandom);
            end
            if ($urandom_range(9) == 0) bus.hold_off = !bus.hold_off;
            #1;
            if (bus.out_ready && prev_rdy) bus.out_next = ($urandom_range(1) == 1);
            else bus.out_next = !bus.locked && ($urandom_range(7) == 0);
            prev_rdy = bus.out_ready;
            #1;
            n0s = bus.src0_next;
            n1s = bus.src1_next;
        end
        bus.out_next = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
